// File: rtl/count_sched_pkg.sv
// Shared types and constants for the count_sched counter scheduler.
package count_sched_pkg;

    localparam int WIDTH = 4;
    localparam int CMIN  = 2;
    localparam int CMAX  = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        OP_LOAD = 1'b0,
        OP_STEP = 1'b1
    } op_t;

endpackage

// File: rtl/count_sched_if.sv
// Requester, counter-pin and response bundle for count_sched.
interface count_sched_if #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 4
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       req_op;
    logic [NREQ-1:0]       req_dir;
    logic [NREQ*WIDTH-1:0] req_arg;
    logic                  cnt_load_n;
    logic                  cnt_up_down;
    logic [WIDTH-1:0]      cnt_data_in;
    logic [WIDTH-1:0]      cnt_data_out;
    logic                  resp_valid;
    logic [IDW-1:0]        resp_id;
    logic [WIDTH-1:0]      resp_count;
    logic                  resp_err;
    logic                  busy;

    // Requesters and the counter model sit on the master side.
    modport master (
        output req_valid, req_op, req_dir, req_arg, cnt_data_out,
        input  req_ready, cnt_load_n, cnt_up_down, cnt_data_in,
        input  resp_valid, resp_id, resp_count, resp_err, busy
    );

    modport slave (
        input  req_valid, req_op, req_dir, req_arg, cnt_data_out,
        output req_ready, cnt_load_n, cnt_up_down, cnt_data_in,
        output resp_valid, resp_id, resp_count, resp_err, busy
    );
endinterface

// File: rtl/count_sched_arb.sv
// One-hot grant generator: rotating priority from ptr_i, or fixed lowest-index
// priority when COUNT_SCHED_FIXED_PRIO_EN is defined.
module count_sched_arb #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req_i,
`ifndef COUNT_SCHED_FIXED_PRIO_EN
    input  logic [IDW-1:0]  ptr_i,
`endif
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  id_o,
    output logic            any_o
);

    // Walk candidates from lowest to highest priority so the best one is written last.
    always_comb begin
        gnt_o = '0;
        id_o  = '0;
        any_o = |req_i;
`ifdef COUNT_SCHED_FIXED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) begin
            id_o = req_i[i] ? IDW'(i) : id_o;
        end
`else
        for (int k = NREQ - 1; k >= 0; k--) begin
            id_o = req_i[(int'(ptr_i) + k) % NREQ] ? IDW'((int'(ptr_i) + k) % NREQ) : id_o;
        end
`endif
        if (any_o) begin
            gnt_o[id_o] = 1'b1;
        end else begin
            gnt_o = '0;
        end
    end

endmodule

// File: rtl/count_sched.sv
// Scheduler sharing one loadable up/down mod counter between NREQ requesters.
// Optional COUNT_SCHED_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module count_sched
    import count_sched_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int WIDTH = count_sched_pkg::WIDTH,
    parameter int CMIN  = count_sched_pkg::CMIN,
    parameter int CMAX  = count_sched_pkg::CMAX
) (
    input logic          clock,
    input logic          resetn,
    count_sched_if.slave bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] arg_q, arg_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [IDW-1:0]   id_q, id_d;
    logic             err_q, err_d;

    logic [NREQ-1:0]  gnt_s;
    logic [IDW-1:0]   gnt_id_s;
    logic             any_s;
    logic [WIDTH-1:0] win_arg_s;
    logic             legal_s;

`ifndef COUNT_SCHED_FIXED_PRIO_EN
    logic [IDW-1:0]   rr_q, rr_d;
`endif

    count_sched_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_i (bus.req_valid),
`ifndef COUNT_SCHED_FIXED_PRIO_EN
        .ptr_i (rr_q),
`endif
        .gnt_o (gnt_s),
        .id_o  (gnt_id_s),
        .any_o (any_s)
    );

    assign win_arg_s = bus.req_arg[int'(gnt_id_s)*WIDTH +: WIDTH];
    assign legal_s   = (arg_q >= WIDTH'(CMIN)) && (arg_q <= WIDTH'(CMAX));

    // State and command registers.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= IDLE;
            op_q    <= OP_LOAD;
            dir_q   <= 1'b0;
            arg_q   <= '0;
            rem_q   <= '0;
            id_q    <= '0;
            err_q   <= 1'b0;
`ifndef COUNT_SCHED_FIXED_PRIO_EN
            rr_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dir_q   <= dir_d;
            arg_q   <= arg_d;
            rem_q   <= rem_d;
            id_q    <= id_d;
            err_q   <= err_d;
`ifndef COUNT_SCHED_FIXED_PRIO_EN
            rr_q    <= rr_d;
`endif
        end
    end

    // Next state and pin drive; reset overrides everything with the freeze pattern.
    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        dir_d           = dir_q;
        arg_d           = arg_q;
        rem_d           = rem_q;
        id_d            = id_q;
        err_d           = err_q;
`ifndef COUNT_SCHED_FIXED_PRIO_EN
        rr_d            = rr_q;
`endif
        bus.req_ready   = '0;
        bus.cnt_load_n  = 1'b0;
        bus.cnt_up_down = 1'b0;
        bus.cnt_data_in = bus.cnt_data_out;
        bus.resp_valid  = 1'b0;
        bus.resp_id     = '0;
        bus.resp_count  = '0;
        bus.resp_err    = 1'b0;
        bus.busy        = resetn && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                bus.req_ready = gnt_s;
                if (any_s) begin
                    op_d  = op_t'(bus.req_op[gnt_id_s]);
                    dir_d = bus.req_dir[gnt_id_s];
                    arg_d = win_arg_s;
                    rem_d = win_arg_s;
                    id_d  = gnt_id_s;
                    err_d = 1'b0;
`ifndef COUNT_SCHED_FIXED_PRIO_EN
                    rr_d  = (int'(gnt_id_s) == NREQ - 1) ? '0 : gnt_id_s + IDW'(1);
`endif
                    if (!bus.req_op[gnt_id_s]) begin
                        state_d = LOAD;
                    end else if (win_arg_s != '0) begin
                        state_d = STEP;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (legal_s) begin
                    bus.cnt_data_in = arg_q;
                end else begin
                    err_d = 1'b1;
                end
                state_d = DONE;
            end
            STEP: begin
                bus.cnt_load_n  = 1'b1;
                bus.cnt_up_down = dir_q;
                rem_d           = rem_q - WIDTH'(1);
                if (rem_q == WIDTH'(1)) begin
                    state_d = DONE;
                end else begin
                    state_d = STEP;
                end
            end
            DONE: begin
                bus.resp_valid = 1'b1;
                bus.resp_id    = id_q;
                bus.resp_count = bus.cnt_data_out;
                bus.resp_err   = err_q;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!resetn) begin
            bus.req_ready   = '0;
            bus.cnt_load_n  = 1'b0;
            bus.cnt_up_down = 1'b0;
            bus.cnt_data_in = bus.cnt_data_out;
            bus.resp_valid  = 1'b0;
            bus.resp_id     = '0;
            bus.resp_count  = '0;
            bus.resp_err    = 1'b0;
        end else begin
            bus.busy = state_q != IDLE;
        end
    end

endmodule

// File: tb/tb_count_sched.sv
// Bench for count_sched: transaction-level model plus a mod-9 counter, checked every cycle.
module tb_count_sched;
    localparam int NREQ = 2;
    localparam int W    = 4;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    count_sched_if #(.NREQ(NREQ), .WIDTH(W)) bus ();

    count_sched #(.NREQ(NREQ), .WIDTH(W), .CMIN(2), .CMAX(10)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    // Counter under control: registered, wraps 10 -> 2 and 2 -> 10.
    logic [W-1:0] cnt_q = 4'd2;
    always @(posedge clock) begin
        if (!bus.cnt_load_n)     cnt_q <= bus.cnt_data_in;
        else if (bus.cnt_up_down) cnt_q <= (cnt_q == 4'd10) ? 4'd2 : cnt_q + 4'd1;
        else                      cnt_q <= (cnt_q == 4'd2) ? 4'd10 : cnt_q - 4'd1;
    end
    assign bus.cnt_data_out = cnt_q;

    int errors = 0;
    int checks = 0;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int step_cnt(input int c, input bit up, input int n);
        int r;
        r = c - 2;
        if (up) r = (r + n) % 9;
        else    r = (r + 9 - (n % 9)) % 9;
        return r + 2;
    endfunction

    function automatic int pick(input logic [NREQ-1:0] v, input int rr);
`ifdef COUNT_SCHED_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
        for (int k = 0; k < NREQ; k++) if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
`endif
        return -1;
    endfunction

    // Model state.
    int cyc = 0;
    bit pend = 1'b0;
    int acc, lat, pw, p_arg, e_cnt, g, off;
    bit p_op, p_dir, e_err;
    int m_count = 2;
    int m_rr = 0;
    int n_acc = 0;
    int n_resp = 0;
    int last_id, last_cnt, last_err, last_lat;
    int q_id[$];
    int q_cnt[$];

    always @(posedge clock) cyc <= cyc + 1;

    // Compare process: outputs are sampled mid-cycle.
    always @(negedge clock) begin
        if (!resetn) begin
            check("rst_ready", int'(bus.req_ready), 0);
            check("rst_busy", int'(bus.busy), 0);
            check("rst_resp_valid", int'(bus.resp_valid), 0);
            check("rst_load_n", int'(bus.cnt_load_n), 0);
            if (pend) begin
                if (!p_op) begin
                    if (cyc - acc > 1 && p_arg >= 2 && p_arg <= 10) m_count = p_arg;
                end else begin
                    m_count = step_cnt(m_count, p_dir, (cyc - acc - 1 < p_arg) ? cyc - acc - 1 : p_arg);
                end
                pend = 1'b0;
            end
            m_rr = 0;
        end else if (!pend) begin
            g = pick(bus.req_valid, m_rr);
            check("idle_ready", int'(bus.req_ready), (g < 0) ? 0 : (1 << g));
            check("idle_busy", int'(bus.busy), 0);
            check("idle_resp_valid", int'(bus.resp_valid), 0);
            check("idle_load_n", int'(bus.cnt_load_n), 0);
            check("idle_count", int'(bus.cnt_data_out), m_count);
            check("idle_data_in", int'(bus.cnt_data_in), m_count);
            if (g >= 0) begin
                pend  = 1'b1;
                acc   = cyc;
                pw    = g;
                p_op  = bus.req_op[g];
                p_dir = bus.req_dir[g];
                p_arg = int'(bus.req_arg[g*W +: W]);
                n_acc++;
                m_rr  = (g + 1) % NREQ;
                if (!p_op) begin
                    lat   = 2;
                    e_err = !(p_arg >= 2 && p_arg <= 10);
                    e_cnt = e_err ? m_count : p_arg;
                end else begin
                    lat   = p_arg + 1;
                    e_err = 1'b0;
                    e_cnt = step_cnt(m_count, p_dir, p_arg);
                end
            end
        end else begin
            off = cyc - acc;
            check("busy_ready", int'(bus.req_ready), 0);
            check("busy_busy", int'(bus.busy), 1);
            check("resp_valid", int'(bus.resp_valid), (off == lat) ? 1 : 0);
            if (off == lat) begin
                check("resp_id", int'(bus.resp_id), pw);
                check("resp_count", int'(bus.resp_count), e_cnt);
                check("resp_err", int'(bus.resp_err), int'(e_err));
                check("done_load_n", int'(bus.cnt_load_n), 0);
                last_id  = int'(bus.resp_id);
                last_cnt = int'(bus.resp_count);
                last_err = int'(bus.resp_err);
                last_lat = off;
                q_id.push_back(last_id);
                q_cnt.push_back(last_cnt);
                m_count  = e_cnt;
                pend     = 1'b0;
                n_resp++;
            end else if (!p_op) begin
                check("load_load_n", int'(bus.cnt_load_n), 0);
                check("load_data_in", int'(bus.cnt_data_in), e_err ? m_count : p_arg);
            end else begin
                check("step_load_n", int'(bus.cnt_load_n), 1);
                check("step_dir", int'(bus.cnt_up_down), int'(p_dir));
            end
        end
    end

    task automatic issue(input int id, input bit op, input bit dir, input int arg,
                         input int x_cnt, input bit x_err, input int x_lat);
        int r0;
        int t;
        r0 = n_resp;
        @(posedge clock); #1;
        bus.req_valid[id]        = 1'b1;
        bus.req_op[id]           = op;
        bus.req_dir[id]          = dir;
        bus.req_arg[id*W +: W]   = arg[W-1:0];
        t = 0;
        do begin @(negedge clock); t++; end while (!bus.req_ready[id] && t < 40);
        check("grant_wait", int'(bus.req_ready[id]), 1);
        @(posedge clock); #1;
        bus.req_valid[id] = 1'b0;
        t = 0;
        while (n_resp == r0 && t < 60) begin @(negedge clock); t++; end
        check("resp_wait", n_resp - r0, 1);
        check("lit_id", last_id, id);
        check("lit_count", last_cnt, x_cnt);
        check("lit_err", last_err, int'(x_err));
        check("lit_latency", last_lat, x_lat);
    endtask

    task automatic hold_both(input int k);
        int a0;
        int r0;
        int t;
        a0 = n_acc;
        r0 = n_resp;
        @(posedge clock); #1;
        bus.req_valid = 2'b11;
        t = 0;
        while (n_acc - a0 < k && t < 100) begin @(posedge clock); #1; t++; end
        bus.req_valid = 2'b00;
        check("hold_grants", n_acc - a0, k);
        t = 0;
        while (n_resp - r0 < k && t < 60) begin @(negedge clock); t++; end
        check("hold_resps", n_resp - r0, k);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int t;
        int r0;
        bus.req_valid = 2'b00;
        bus.req_op    = 2'b00;
        bus.req_dir   = 2'b00;
        bus.req_arg   = 8'h00;
        repeat (3) @(posedge clock);
        #1 resetn = 1'b1;

        issue(0, 1'b0, 1'b0, 7, 7, 1'b0, 2);
        issue(0, 1'b0, 1'b0, 9, 9, 1'b0, 2);
        issue(1, 1'b1, 1'b1, 3, 3, 1'b0, 4);
        issue(1, 1'b0, 1'b0, 5, 5, 1'b0, 2);

        base = q_id.size();
        bus.req_op  = 2'b11;
        bus.req_dir = 2'b00;
        bus.req_arg = 8'h11;
        hold_both(4);
`ifdef COUNT_SCHED_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) check("alt_id", q_id[base+i], 0);
`else
        check("alt_id0", q_id[base],   0);
        check("alt_id1", q_id[base+1], 1);
        check("alt_id2", q_id[base+2], 0);
        check("alt_id3", q_id[base+3], 1);
`endif
        check("alt_cnt0", q_cnt[base],   4);
        check("alt_cnt1", q_cnt[base+1], 3);
        check("alt_cnt2", q_cnt[base+2], 2);
        check("alt_cnt3", q_cnt[base+3], 10);

        issue(0, 1'b0, 1'b0, 12, 10, 1'b1, 2);
        issue(1, 1'b0, 1'b0, 1, 10, 1'b1, 2);
        issue(0, 1'b1, 1'b0, 0, 10, 1'b0, 1);

        repeat (20) @(negedge clock);
        check("idle_hold_lit", int'(bus.cnt_data_out), 10);

        // Reset in the second cycle of STEP up 5; a stray valid from requester 1 meanwhile.
        r0 = n_resp;
        @(posedge clock); #1;
        bus.req_valid[0] = 1'b1; bus.req_op[0] = 1'b1; bus.req_dir[0] = 1'b1; bus.req_arg[3:0] = 4'd5;
        t = 0;
        do begin @(negedge clock); t++; end while (!bus.req_ready[0] && t < 40);
        check("rst_grant_wait", int'(bus.req_ready[0]), 1);
        @(posedge clock); #1;
        bus.req_valid[0] = 1'b0;
        bus.req_valid[1] = 1'b1; bus.req_op[1] = 1'b0; bus.req_arg[7:4] = 4'd3;
        @(posedge clock); #1;
        resetn = 1'b0;
        bus.req_valid[1] = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        resetn = 1'b1;
        @(negedge clock);
        check("rst_no_resp", n_resp - r0, 0);
        check("rst_count_lit", int'(bus.cnt_data_out), 2);

        base = q_id.size();
        bus.req_op  = 2'b00;
        bus.req_arg = 8'h64;
        hold_both(2);
        check("post_rst_id0", q_id[base], 0);
        check("post_rst_cnt0", q_cnt[base], 4);
`ifdef COUNT_SCHED_FIXED_PRIO_EN
        check("post_rst_id1", q_id[base+1], 0);
        check("post_rst_cnt1", q_cnt[base+1], 4);
`else
        check("post_rst_id1", q_id[base+1], 1);
        check("post_rst_cnt1", q_cnt[base+1], 6);
`endif

        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
